// File: rtl/player_health_tracker_if.sv
// Interface bundling the collision-handler hit level and the round control
// coming into the health tracker with the health/status outputs going to
// the HUD and the top-level game FSM.
interface player_health_tracker_if #(
    parameter int HEALTH_W = 3
);
    logic                start;
    logic                health_update;
    logic [HEALTH_W-1:0] health;
    logic                hit_pulse;
    logic                invuln;
    logic                alive;
    logic                game_over;

    // Game logic side: drives round control and hit level, observes status.
    modport master (
        output start,
        output health_update,
        input  health,
        input  hit_pulse,
        input  invuln,
        input  alive,
        input  game_over
    );

    // Health tracker side.
    modport slave (
        input  start,
        input  health_update,
        output health,
        output hit_pulse,
        output invuln,
        output alive,
        output game_over
    );
endinterface

// File: rtl/player_health_tracker.sv
// Player health tracker: one point lost per accepted hit, followed by a
// fixed invulnerability window so a single sustained overlap only costs one
// point per window. Flags game over at zero health; start (re)loads a round.
// Every output is a register so the HUD and game FSM see glitch-free levels.
module player_health_tracker #(
    parameter int MAX_HEALTH    = 3,
    parameter int HEALTH_W      = 3,
    parameter int IFRAME_CYCLES = 25_000_000,
    parameter int IFRAME_W      = 25
) (
    input  logic                   clk,
    input  logic                   rst,
    player_health_tracker_if.slave bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] PLAY   = 2'd1;
    localparam logic [1:0] INVULN = 2'd2;
    localparam logic [1:0] DEAD   = 2'd3;

    localparam logic [HEALTH_W-1:0] HEALTH_FULL = HEALTH_W'(MAX_HEALTH);
    localparam logic [HEALTH_W-1:0] HEALTH_ONE  = HEALTH_W'(1);
    // Counter is loaded with N-1 and the window ends on the cycle it reads 0,
    // giving exactly IFRAME_CYCLES cycles with invuln high.
    localparam logic [IFRAME_W-1:0] IFRAME_LOAD = IFRAME_W'(IFRAME_CYCLES - 1);

    logic [1:0]          state, state_n;
    logic [HEALTH_W-1:0] health_q, health_n;
    logic [IFRAME_W-1:0] counter, counter_n;
    logic                hit_n;

    // Next-state logic: start overrides any hit in the same cycle.
    always_comb begin
        state_n   = state;
        health_n  = health_q;
        counter_n = counter;
        hit_n     = 1'b0;
        if (bus.start) begin
            state_n   = PLAY;
            health_n  = HEALTH_FULL;
            counter_n = '0;
        end else begin
            case (state)
                PLAY: begin
                    if (bus.health_update) begin
                        hit_n = 1'b1;
                        if (health_q > HEALTH_ONE) begin
                            health_n  = health_q - 1'b1;
                            counter_n = IFRAME_LOAD;
                            state_n   = INVULN;
                        end else begin
                            // Last point (or defensive zero): clamp, never wrap.
                            health_n = '0;
                            state_n  = DEAD;
                        end
                    end
                end
                INVULN: begin
                    if (counter != '0) counter_n = counter - 1'b1;
                    else               state_n   = PLAY;
                end
                DEAD: begin
                    health_n = '0;
                end
                default: begin
                    // IDLE: hits ignored until the round is started.
                end
            endcase
        end
    end

    // State and registered outputs; status flags decoded from the next state
    // so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            health_q      <= '0;
            counter       <= '0;
            bus.hit_pulse <= 1'b0;
            bus.invuln    <= 1'b0;
            bus.alive     <= 1'b0;
            bus.game_over <= 1'b0;
        end else begin
            state         <= state_n;
            health_q      <= health_n;
            counter       <= counter_n;
            bus.hit_pulse <= hit_n;
            bus.invuln    <= (state_n == INVULN);
            bus.alive     <= (state_n == PLAY) || (state_n == INVULN);
            bus.game_over <= (state_n == DEAD);
        end
    end

    assign bus.health = health_q;

endmodule

// File: tb/tb_player_health_tracker.sv
// Self-checking bench: directed scenarios followed by randomized rst/start/hit
// traffic, all compared cycle by cycle against a timeline-based model.
module tb_player_health_tracker;

    localparam int MAX_HEALTH    = 3;
    localparam int HEALTH_W      = 3;
    localparam int IFRAME_CYCLES = 4;
    localparam int IFRAME_W      = 3;

    logic clk = 1'b0;
    logic rst;

    player_health_tracker_if #(.HEALTH_W(HEALTH_W)) bus ();

    player_health_tracker #(
        .MAX_HEALTH    (MAX_HEALTH),
        .HEALTH_W      (HEALTH_W),
        .IFRAME_CYCLES (IFRAME_CYCLES),
        .IFRAME_W      (IFRAME_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #10 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    endtask

    // Reference model: health plus the edge index at which the next hit may
    // land (hit edge + window + 1). No state encoding, just a timeline.
    int  cyc      = 0;
    int  m_health = 0;
    int  ready_at = 0;
    bit  m_round  = 0;
    bit  m_dead   = 0;
    bit  m_pulse  = 0;

    task automatic step(input bit r, input bit s, input bit hu, input string tag);
        bit exp_inv;
        rst               = r;
        bus.start         = s;
        bus.health_update = hu;
        @(posedge clk);
        m_pulse = 0;
        if (r) begin
            m_health = 0; m_round = 0; m_dead = 0; ready_at = 0;
        end else if (s) begin
            m_health = MAX_HEALTH; m_round = 1; m_dead = 0; ready_at = cyc;
        end else if (m_round && !m_dead && hu && cyc >= ready_at) begin
            m_health = m_health - 1;
            m_pulse  = 1;
            if (m_health == 0) m_dead = 1;
            else               ready_at = cyc + IFRAME_CYCLES + 1;
        end
        exp_inv = m_round && !m_dead && (cyc < ready_at - 1);
        #1;
        chk({tag, ".health"},    int'(bus.health),    m_health);
        chk({tag, ".hit_pulse"}, int'(bus.hit_pulse), int'(m_pulse));
        chk({tag, ".invuln"},    int'(bus.invuln),    int'(exp_inv));
        chk({tag, ".alive"},     int'(bus.alive),     int'(m_round && !m_dead));
        chk({tag, ".game_over"}, int'(bus.game_over), int'(m_round && m_dead));
        cyc++;
    endtask

    int pulses;
    bit hu_lvl;

    initial begin
        rst = 1'b1; bus.start = 1'b0; bus.health_update = 1'b0;

        // 1: reset, then hits in IDLE do nothing
        step(1, 0, 0, "rst");
        step(1, 0, 1, "rst");
        chk("rst.health0", int'(bus.health), 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, "idle");

        // 2: single hit, then 4-cycle window
        step(0, 1, 0, "start");
        step(0, 0, 1, "hit1");
        chk("hit1.health2", int'(bus.health), 2);
        chk("hit1.pulse", int'(bus.hit_pulse), 1);
        for (int i = 0; i < 6; i++) step(0, 0, 0, "window");
        chk("window.play", int'(bus.alive && !bus.invuln), 1);

        // 3: continuous overlap from full health: hits at 0,5,10 only
        step(0, 1, 0, "start3");
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 1, "hold");
            if (bus.hit_pulse) pulses++;
        end
        chk("hold.pulses", pulses, 3);
        chk("hold.game_over", int'(bus.game_over), 1);

        // 4: DEAD holds, start revives
        for (int i = 0; i < 6; i++) step(0, 0, i[0], "dead");
        step(0, 1, 0, "revive");
        chk("revive.health", int'(bus.health), MAX_HEALTH);

        // 5: start wins over a hit at health 1
        step(0, 0, 1, "h5a");
        for (int i = 0; i < 5; i++) step(0, 0, 0, "h5w");
        step(0, 0, 1, "h5b");
        for (int i = 0; i < 5; i++) step(0, 0, 0, "h5w");
        chk("h5.health1", int'(bus.health), 1);
        step(0, 1, 1, "start_vs_hit");
        chk("svh.health", int'(bus.health), MAX_HEALTH);
        chk("svh.pulse", int'(bus.hit_pulse), 0);

        // 6: reset mid-window with counter at 2
        step(0, 0, 1, "h6");
        step(0, 0, 0, "h6w");
        step(1, 0, 0, "rst_inv");
        chk("rst_inv.invuln", int'(bus.invuln), 0);
        chk("rst_inv.health", int'(bus.health), 0);

        // Random traffic: hit level in runs, occasional start/rst
        hu_lvl = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(5, 0) == 0) hu_lvl = ~hu_lvl;
            step($urandom_range(79, 0) == 0, $urandom_range(24, 0) == 0, hu_lvl, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
